// File: rtl/biquad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : biquad_pkg                                                      |
// | Purpose  : Shared types and constants for the biquad filter slot.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package biquad_pkg;

  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    A1 = 3'd3,
    A2 = 3'd4
  } coef_idx_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int NUM_COEF      = 5;
  localparam int COEF_FRAC_DEF = 30;

  function automatic longint coef_one(input int frac);
    return longint'(1) <<< frac;
  endfunction

  localparam longint COEF_ONE = coef_one(COEF_FRAC_DEF);

endpackage
`default_nettype wire

// File: rtl/biquad_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : biquad_mac                                                      |
// | Purpose  : Multiply-accumulate with round-half-up and output saturation.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module biquad_mac #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 32,
  parameter int COEF_FRAC = 30,
  parameter int ACC_W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] c,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);

  localparam int c_prod_w = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] c_half =
    {{(ACC_W-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] c_max =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_min =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] c_ymax = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] c_ymin = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [c_prod_w-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_term;
  logic signed [ACC_W-1:0]    w_rnd;
  logic signed [ACC_W-1:0]    w_shr;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod = x * c;
  assign w_term = {{(ACC_W-c_prod_w){w_prod[c_prod_w-1]}}, w_prod};

  // clr restarts the sum with the current term, so no idle cycle between channels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= (clr ? '0 : r_acc) + w_term;
    end
  end

  assign w_rnd = r_acc + c_half;
  assign w_shr = w_rnd >>> COEF_FRAC;

  always_comb begin
    y   = w_shr[DATA_W-1:0];
    sat = 1'b0;
    if (w_shr > c_max) begin
      y   = c_ymax;
      sat = 1'b1;
    end else if (w_shr < c_min) begin
      y   = c_ymin;
      sat = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/biquad_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : biquad_filter                                                   |
// | Purpose  : Multi-channel DF-I biquad, one shared MAC, runtime coefficients. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module biquad_filter
  import biquad_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 32,
  parameter int COEF_FRAC = 30,
  parameter int ACC_W     = 64,
  parameter int CH        = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH*DATA_W-1:0]   in_data,
  output logic                   out_valid,
  output logic [CH*DATA_W-1:0]   out_data,
  output logic                   sat_flag,
  input  logic                   bypass,
  input  logic                   coef_we,
  input  logic [2:0]             coef_sel,
  input  logic [COEF_W-1:0]      coef_wdata,
  input  logic                   coef_commit
);

  localparam int c_chw = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [c_chw-1:0] c_ch_last = c_chw'(CH - 1);
  localparam longint c_one_l =
    (COEF_FRAC == COEF_FRAC_DEF) ? COEF_ONE : coef_one(COEF_FRAC);
  localparam logic signed [COEF_W-1:0] c_coef_one = COEF_W'(c_one_l);

  typedef logic signed [DATA_W-1:0] smp_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  state_e           r_state;
  logic [2:0]       r_tap;
  logic [c_chw-1:0] r_ch;
  logic             r_byp;
  logic             r_pend;

  coef_t r_shadow [NUM_COEF];
  coef_t r_active [NUM_COEF];
  coef_t w_shadow_nxt [NUM_COEF];

  smp_t r_x0 [CH];
  smp_t r_x1 [CH];
  smp_t r_x2 [CH];
  smp_t r_y1 [CH];
  smp_t r_y2 [CH];
  smp_t r_res [CH];
  smp_t w_y [CH];

  smp_t  w_mac_x;
  coef_t w_mac_c;
  smp_t  w_mac_y;
  logic  w_mac_sat;
  logic  w_mac_en;
  logic  w_mac_clr;
  logic  w_accept;
  logic  w_apply;

  assign w_accept  = (r_state == S_IDLE) && in_ready && in_valid;
  assign w_apply   = (r_state == S_IDLE) && (r_pend || coef_commit);
  assign w_mac_en  = (r_state == S_MAC);
  assign w_mac_clr = (r_tap == B0);

  // Same-cycle write is folded in so a simultaneous commit picks it up
  always_comb begin
    for (int k = 0; k < NUM_COEF; k++) begin
      w_shadow_nxt[k] = r_shadow[k];
    end
    if (coef_we && (coef_sel < 3'(NUM_COEF))) begin
      w_shadow_nxt[coef_sel] = coef_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_COEF; k++) begin
        r_shadow[k] <= (k == 0) ? c_coef_one : '0;
        r_active[k] <= (k == 0) ? c_coef_one : '0;
      end
      r_pend <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_COEF; k++) begin
        r_shadow[k] <= w_shadow_nxt[k];
      end
      if (w_apply) begin
        for (int k = 0; k < NUM_COEF; k++) begin
          r_active[k] <= w_shadow_nxt[k];
        end
        r_pend <= 1'b0;
      end else if (coef_commit) begin
        r_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    w_mac_c = r_active[r_tap];
    w_mac_x = r_x0[r_ch];
    case (r_tap)
      B1:      w_mac_x = r_x1[r_ch];
      B2:      w_mac_x = r_x2[r_ch];
      A1:      w_mac_x = r_y1[r_ch];
      A2:      w_mac_x = r_y2[r_ch];
      default: w_mac_x = r_x0[r_ch];
    endcase
  end

  // Last channel's result is still in the MAC during DONE
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_y[i] = r_res[i];
    end
    w_y[CH-1] = w_mac_y;
  end

  biquad_mac #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC),
    .ACC_W     (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (w_mac_en),
    .clr   (w_mac_clr),
    .x     (w_mac_x),
    .c     (w_mac_c),
    .y     (w_mac_y),
    .sat   (w_mac_sat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tap     <= B0;
      r_ch      <= '0;
      r_byp     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        r_x0[i]  <= '0;
        r_x1[i]  <= '0;
        r_x2[i]  <= '0;
        r_y1[i]  <= '0;
        r_y2[i]  <= '0;
        r_res[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (w_apply) begin
        sat_flag <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (w_accept) begin
            for (int i = 0; i < CH; i++) begin
              r_x0[i] <= in_data[i*DATA_W +: DATA_W];
            end
            r_byp    <= bypass;
            r_tap    <= B0;
            r_ch     <= '0;
            in_ready <= 1'b0;
            r_state  <= S_MAC;
          end
        end
        S_MAC: begin
          // Previous channel's sum is final while the next channel's first tap runs
          if ((r_tap == B0) && (r_ch != '0)) begin
            r_res[r_ch - c_chw'(1)] <= w_mac_y;
            if (w_mac_sat) begin
              sat_flag <= 1'b1;
            end
          end
          if (r_tap == A2) begin
            r_tap <= B0;
            if (r_ch == c_ch_last) begin
              r_state <= S_DONE;
            end else begin
              r_ch <= r_ch + c_chw'(1);
            end
          end else begin
            r_tap <= r_tap + 3'd1;
          end
        end
        S_DONE: begin
          if (w_mac_sat) begin
            sat_flag <= 1'b1;
          end
          for (int i = 0; i < CH; i++) begin
            out_data[i*DATA_W +: DATA_W] <= r_byp ? r_x0[i] : w_y[i];
            r_x2[i] <= r_x1[i];
            r_x1[i] <= r_x0[i];
            r_y2[i] <= r_y1[i];
            r_y1[i] <= w_y[i];
          end
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_biquad_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_biquad_filter                                                |
// | Purpose  : Self-checking bench for biquad_filter (CH=2) with a ref model.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_biquad_filter;

  localparam int CH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        sat_flag;
  logic        bypass;
  logic        coef_we;
  logic [2:0]  coef_sel;
  logic [31:0] coef_wdata;
  logic        coef_commit;

  always #5 clk = ~clk;

  biquad_filter #(
    .DATA_W(16), .COEF_W(32), .COEF_FRAC(30), .ACC_W(64), .CH(CH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .sat_flag    (sat_flag),
    .bypass      (bypass),
    .coef_we     (coef_we),
    .coef_sel    (coef_sel),
    .coef_wdata  (coef_wdata),
    .coef_commit (coef_commit)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: coefficient banks as plain integers, history per channel
  int m_shadow [5];
  int m_active [5];
  bit m_pend;
  bit m_sat;
  longint m_x1 [CH];
  longint m_x2 [CH];
  longint m_y1 [CH];
  longint m_y2 [CH];

  typedef struct {
    logic [31:0] din;
    bit          byp;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int q7(input int num);
    return num * 8388608;  // num/128 in Q2.30
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      m_shadow[k] = (k == 0) ? 32'sd1073741824 : 0;
    end
    m_active = m_shadow;
    m_pend = 1'b0;
    m_sat  = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_x1[c] = 0; m_x2[c] = 0; m_y1[c] = 0; m_y2[c] = 0;
    end
  endtask

  task automatic model_step(input logic [31:0] d, input bit byp, output logic [31:0] exp);
    longint x0, acc, y;
    if (m_pend) begin
      m_active = m_shadow;
      m_pend = 1'b0;
      m_sat  = 1'b0;
    end
    for (int c = 0; c < CH; c++) begin
      x0  = longint'($signed(d[c*16 +: 16]));
      acc = longint'(m_active[0]) * x0 + longint'(m_active[1]) * m_x1[c]
          + longint'(m_active[2]) * m_x2[c] + longint'(m_active[3]) * m_y1[c]
          + longint'(m_active[4]) * m_y2[c];
      y = (acc + (longint'(1) <<< 29)) >>> 30;
      if (y > 32767)  begin y = 32767;  m_sat = 1'b1; end
      if (y < -32768) begin y = -32768; m_sat = 1'b1; end
      exp[c*16 +: 16] = byp ? d[c*16 +: 16] : 16'(y);
      m_x2[c] = m_x1[c]; m_x1[c] = x0;
      m_y2[c] = m_y1[c]; m_y1[c] = y;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; bypass = 1'b0;
    coef_we = 1'b0; coef_commit = 1'b0; coef_sel = '0; coef_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset sat_flag", sat_flag, 0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("in_ready after release", in_ready, 1);
  endtask

  task automatic write_coef(input int sel, input int val);
    coef_we = 1'b1; coef_sel = sel[2:0]; coef_wdata = val;
    @(negedge clk);
    coef_we = 1'b0;
    if (sel < 5) m_shadow[sel] = val;
  endtask

  // Commit while idle, optionally with a same-cycle shadow write
  task automatic commit(input int sel, input int val, input bit wr);
    coef_commit = 1'b1; coef_we = wr; coef_sel = sel[2:0]; coef_wdata = val;
    @(negedge clk);
    coef_commit = 1'b0; coef_we = 1'b0;
    if (wr && sel < 5) m_shadow[sel] = val;
    m_active = m_shadow;
    m_pend = 1'b0;
    m_sat  = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit byp, input bit midwr,
                      input int mw_sel, input int mw_val,
                      output logic [31:0] got, output logic [31:0] exp);
    int w, lat;
    in_data = d; bypass = byp; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 40) begin @(negedge clk); w++; end
    if (!in_ready) begin
      check("accept timeout", 0, 1);
      in_valid = 1'b0; got = '0; exp = '1;
      return;
    end
    @(posedge clk);
    model_step(d, byp, exp);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (midwr && lat == 3) begin
        coef_we = 1'b1; coef_sel = mw_sel[2:0]; coef_wdata = mw_val; coef_commit = 1'b1;
        if (mw_sel < 5) m_shadow[mw_sel] = mw_val;
        m_pend = 1'b1;
      end else begin
        coef_we = 1'b0; coef_commit = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    coef_we = 1'b0; coef_commit = 1'b0;
    check("latency", lat, 11);
    got = out_data;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [4];
    logic [31:0] got, exp;
    int          acc_t [$];
    int          nout, nbad;

    tbl[0] = '{32'hFB2E_03E8, 1'b0, 32'hFB2E_03E8};
    tbl[1] = '{32'h7FFF_8000, 1'b0, 32'h7FFF_8000};
    tbl[2] = '{32'h0001_FFFF, 1'b1, 32'h0001_FFFF};
    tbl[3] = '{32'h1234_ABCD, 1'b0, 32'h1234_ABCD};

    do_reset();

    // Passthrough bank after reset
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].din, tbl[i].byp, 1'b0, 0, 0, got, exp);
      check("table out", got, tbl[i].exp);
    end

    // Impulse response; a2 written in the same cycle as the commit
    do_reset();
    write_coef(0, q7(117));
    write_coef(1, q7(-234));
    write_coef(2, q7(117));
    write_coef(3, q7(232));
    commit(4, q7(-106), 1'b1);
    send(32'h0000_4000, 1'b0, 1'b0, 0, 0, got, exp);
    check("impulse y0", $signed(got[15:0]), 14976);
    check("impulse y0 ch1", $signed(got[31:16]), 0);
    send(32'h0000_0000, 1'b0, 1'b0, 0, 0, got, exp);
    check("impulse y1", $signed(got[15:0]), -2808);
    send(32'h0000_0000, 1'b0, 1'b0, 0, 0, got, exp);
    check("impulse y2 model", got, exp);

    // Saturation and sat_flag clearing by a commit (sel 7 write ignored)
    do_reset();
    commit(0, q7(192), 1'b1);
    send(32'h0000_7530, 1'b0, 1'b0, 0, 0, got, exp);
    check("sat pos", $signed(got[15:0]), 32767);
    check("sat_flag set", sat_flag, 1);
    send(32'h0000_8AD0, 1'b0, 1'b0, 0, 0, got, exp);
    check("sat neg", $signed(got[15:0]), -32768);
    commit(7, 0, 1'b1);
    check("sat_flag cleared", sat_flag, 0);

    // Commit during MAC: in-flight sample keeps b0=1.5, next uses b0=0.5
    send(32'h00C8_03E8, 1'b0, 1'b1, 0, q7(64), got, exp);
    check("mid-commit old bank", got, 32'h012C_05DC);
    send(32'h00C8_03E8, 1'b0, 1'b0, 0, 0, got, exp);
    check("mid-commit new bank", got, 32'h0064_01F4);

    // Reset in the middle of MAC
    in_data = 32'h1111_2222; bypass = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset out_valid", out_valid, 0);
    check("midreset out_data", out_data, 0);
    check("midreset in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    nbad = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) nbad++;
    end
    check("no out_valid after reset", nbad, 0);
    // b0 must be back at 1.0 and history zeroed: y = x0 + x1
    commit(1, q7(128), 1'b1);
    send(32'h0100_0050, 1'b0, 1'b0, 0, 0, got, exp);
    check("post-reset y0", got, 32'h0100_0050);
    send(32'h0002_0003, 1'b0, 1'b0, 0, 0, got, exp);
    check("post-reset y1", got, 32'h0102_0053);

    // Back-to-back with in_valid held high and bypass
    do_reset();
    in_data = 32'h5A5A_8001; bypass = 1'b1; in_valid = 1'b1;
    nout = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (in_ready) acc_t.push_back(cyc);
      @(negedge clk);
      if (out_valid) begin
        nout++;
        check("b2b bypass out", out_data, 32'h5A5A_8001);
      end
    end
    in_valid = 1'b0; bypass = 1'b0;
    check("b2b accepts", acc_t.size(), 4);
    for (int i = 1; i < acc_t.size(); i++) begin
      check("b2b spacing", acc_t[i] - acc_t[i-1], 12);
    end
    check("b2b outputs", nout, 3);

    // Randomized coefficients and samples against the model
    do_reset();
    for (int k = 0; k < 5; k++) begin
      write_coef(k, int'($urandom_range(0, 32'h7FFF_FFFF)) - 1073741824);
    end
    commit(7, 0, 1'b0);
    for (int n = 0; n < 24; n++) begin
      send($urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 32'h7FFF_FFFF)) - 1073741824,
           got, exp);
      check("random out", got, exp);
      check("random sat_flag", sat_flag, m_sat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
